// File: rtl/memory_controller_pkg.sv
// memory_controller_pkg: shared FSM state, access-size and IO-address encodings
package memory_controller_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] IO_TAG = 2'b11;
  function automatic logic [2:0] size_len(input logic [1:0] size);
    return size == SIZE_BYTE ? 3'd1 : size == SIZE_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/memory_controller.sv
// memory_controller: arbitrates IF and LSB onto the byte-wide RAM port, one byte per cycle
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IO_MASK_BIT = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              roll_back,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              finish_fetch,
  output logic [31:0]       instruction_out,
  output logic              is_idle,
  input  logic              lsb_start,
  input  logic              lsb_is_store,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_finish,
  output logic [31:0]       lsb_rdata
);
  state_t state, state_nx;
  logic [2:0] cnt, len, k;
  logic [1:0] kb;
  logic [ADDR_W-1:0] base, addr_k;
  logic [31:0] wdata;
  logic last_lsb, wr_reg, lsb_io, if_req, lsb_req, grant_if, grant_lsb, last_k, done;
  assign mem_wr = wr_reg & rdy_in;
  assign is_idle = state == IDLE;
  // k is the index of the edge being taken, counted from the grant edge
  always_comb begin
    k = cnt + 3'd1;
    kb = k[1:0] - 2'd2;
    addr_k = base + ADDR_W'(k);
    lsb_io = lsb_addr[IO_MASK_BIT -: 2] == IO_TAG;
    if_req = fetch_start & ~roll_back;
    lsb_req = lsb_start & (lsb_is_store ? ~(lsb_io & io_buffer_full) : ~roll_back);
    grant_lsb = lsb_req & (~if_req | ~last_lsb);
    grant_if = if_req & ~grant_lsb;
    last_k = state == STORE ? k == len : k == len + 3'd1;
    done = state != IDLE & last_k & (state == STORE | ~roll_back);
    state_nx = state == IDLE ? (grant_lsb ? (lsb_is_store ? STORE : LOAD) : grant_if ? FETCH : IDLE)
             : (last_k | (roll_back & state != STORE)) ? IDLE : state;
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      base <= '0;
      wdata <= '0;
      last_lsb <= 1'b0;
      wr_reg <= 1'b0;
      mem_a <= '0;
      mem_dout <= '0;
      finish_fetch <= 1'b0;
      lsb_finish <= 1'b0;
    end else if (rdy_in) begin
      state <= state_nx;
      finish_fetch <= done & state == FETCH;
      lsb_finish <= done & state != FETCH;
      if (state == IDLE) begin
        if (grant_lsb | grant_if) begin
          base <= grant_lsb ? lsb_addr : pc_in;
          mem_a <= grant_lsb ? lsb_addr : pc_in;
          len <= grant_lsb ? size_len(lsb_size) : 3'd4;
          wdata <= lsb_wdata;
          last_lsb <= grant_lsb;
          wr_reg <= grant_lsb & lsb_is_store;
          mem_dout <= lsb_wdata[7:0];
          cnt <= '0;
        end
      end else begin
        cnt <= state_nx == IDLE ? 3'd0 : k;
        if (k < len) mem_a <= addr_k;
        if (state == STORE) begin
          wr_reg <= k < len;
          if (k < len) mem_dout <= wdata[{k[1:0], 3'b000} +: 8];
        end
      end
    end
  // RAM returns each byte one cycle late, so edge k captures byte k-2
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      instruction_out <= '0;
      lsb_rdata <= '0;
    end else if (rdy_in) begin
      if (state == IDLE && grant_lsb && !lsb_is_store) lsb_rdata <= '0;
      if (state == FETCH && k >= 3'd2) instruction_out[{kb, 3'b000} +: 8] <= mem_din;
      if (state == LOAD && k >= 3'd2) lsb_rdata[{kb, 3'b000} +: 8] <= mem_din;
    end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: randomized requester traffic against a byte-array RAM and a
// reference memory image with latencies derived from the access rules
module tb_memory_controller;
  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, roll_back = 1'b0, io_buffer_full = 1'b0;
  logic [7:0] mem_din, mem_dout;
  logic [31:0] mem_a;
  logic mem_wr;
  logic fetch_start = 1'b0;
  logic [31:0] pc_in = '0;
  logic finish_fetch, is_idle, lsb_finish;
  logic [31:0] instruction_out, lsb_rdata;
  logic lsb_start = 1'b0, lsb_is_store = 1'b0;
  logic [1:0] lsb_size = '0;
  logic [31:0] lsb_addr = '0, lsb_wdata = '0;
  logic [7:0] ram [0:262143];
  logic [7:0] exp_mem [0:262143];
  logic [31:0] a_seq [0:63];
  int n_cmp = 0, n_err = 0;

  memory_controller dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .fetch_start(fetch_start), .pc_in(pc_in), .finish_fetch(finish_fetch),
    .instruction_out(instruction_out), .is_idle(is_idle), .lsb_start(lsb_start),
    .lsb_is_store(lsb_is_store), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_finish(lsb_finish), .lsb_rdata(lsb_rdata)
  );

  always #5 clk_in = ~clk_in;

  // RAM pauses with the rest of the system while rdy_in is low
  always @(posedge clk_in) if (rdy_in) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 32'h2FFF0));
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] v, ai;
    v = '0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v = v | (32'(exp_mem[ai[17:0]]) << (8 * i));
    end
    return v;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] v, ai;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      ai = a + 32'(i);
      v = v | (32'(ram[ai[17:0]]) << (8 * i));
    end
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] d);
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      exp_mem[ai[17:0]] = 8'(d >> (8 * i));
    end
  endtask

  task automatic run_fetch(input logic [31:0] pc, output int lat, output logic [31:0] word);
    pc_in = pc;
    fetch_start = 1'b1;
    lat = -1;
    word = 'x;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      a_seq[6'(c)] = mem_a;
      if (finish_fetch) begin
        lat = c;
        word = instruction_out;
      end
    end
    fetch_start = 1'b0;
  endtask

  task automatic run_lsb(input logic st, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int wrs, output logic [31:0] rd);
    lsb_is_store = st;
    lsb_size = sz;
    lsb_addr = a;
    lsb_wdata = d;
    lsb_start = 1'b1;
    lat = -1;
    wrs = 0;
    rd = 'x;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      a_seq[6'(c)] = mem_a;
      if (mem_wr) wrs++;
      if (lsb_finish) begin
        lat = c;
        rd = lsb_rdata;
      end
    end
    lsb_start = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({mem_a, mem_dout, mem_wr, finish_fetch, lsb_finish, instruction_out, lsb_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: mem_a=%h dout=%h wr=%b ff=%b lf=%b ins=%h rd=%h, want all 0",
               mem_a, mem_dout, mem_wr, finish_fetch, lsb_finish, instruction_out, lsb_rdata);
    end
    n_cmp++;
    if (is_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", is_idle); end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    logic [31:0] pc, w;
    int lat;
    logic seq_ok;
    for (int t = 0; t < 4; t++) begin
      pc = t == 0 ? 32'h100 : rand_addr();
      if (t == 0) begin
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
        exp_mem[18'h100] = 8'h13; exp_mem[18'h101] = 8'h05; exp_mem[18'h102] = 8'h00; exp_mem[18'h103] = 8'h00;
      end
      run_fetch(pc, lat, w);
      n_cmp++;
      if (lat !== 6) begin n_err++; $display("FAIL fetch_latency: got %0d want 6", lat); end
      n_cmp++;
      if (w !== ref_read(pc, 4)) begin n_err++; $display("FAIL fetch_data: got %h want %h", w, ref_read(pc, 4)); end
      if (t == 0) begin
        n_cmp++;
        if (w !== 32'h00000513) begin n_err++; $display("FAIL fetch_0x100: got %h want 00000513", w); end
      end
      seq_ok = 1'b1;
      for (int i = 0; i < 4; i++) if (a_seq[6'(i + 1)] !== pc + 32'(i)) seq_ok = 1'b0;
      n_cmp++;
      if (!seq_ok) begin
        n_err++;
        $display("FAIL fetch_addr_seq: got %h %h %h %h from base %h", a_seq[1], a_seq[2], a_seq[3], a_seq[4], pc);
      end
      tick();
      n_cmp++;
      if ({finish_fetch, is_idle} !== 2'b01) begin
        n_err++;
        $display("FAIL fetch_pulse_width: finish=%b idle=%b want 0/1", finish_fetch, is_idle);
      end
    end
  endtask

  task automatic test_load();
    logic [31:0] a, rd;
    logic [1:0] sz;
    int n, lat, wrs;
    for (int t = 0; t < 7; t++) begin
      a = t == 0 ? 32'hFFFF_FFFE : rand_addr();
      sz = t == 0 ? 2'b10 : 2'($urandom_range(0, 2));
      n = nbytes(sz);
      run_lsb(1'b0, sz, a, $urandom, lat, wrs, rd);
      n_cmp++;
      if (lat !== n + 2) begin n_err++; $display("FAIL load_latency: got %0d want %0d", lat, n + 2); end
      n_cmp++;
      if (rd !== ref_read(a, n)) begin n_err++; $display("FAIL load_data: addr %h got %h want %h", a, rd, ref_read(a, n)); end
      n_cmp++;
      if (wrs !== 0) begin n_err++; $display("FAIL load_no_write: got %0d write cycles want 0", wrs); end
      if (t == 0) begin
        n_cmp++;
        if (a_seq[3] !== 32'h0) begin n_err++; $display("FAIL load_addr_wrap: got %h want 00000000", a_seq[3]); end
      end
    end
  endtask

  task automatic test_store();
    logic [31:0] a, d, rd;
    logic [1:0] sz;
    int n, lat, wrs;
    for (int t = 0; t < 7; t++) begin
      a = t == 0 ? 32'h200 : rand_addr();
      sz = t == 0 ? 2'b10 : 2'($urandom_range(0, 2));
      d = t == 0 ? 32'hDEAD_BEEF : $urandom;
      n = nbytes(sz);
      run_lsb(1'b1, sz, a, d, lat, wrs, rd);
      ref_write(a, n, d);
      n_cmp++;
      if (lat !== n + 1) begin n_err++; $display("FAIL store_latency: got %0d want %0d", lat, n + 1); end
      n_cmp++;
      if (wrs !== n) begin n_err++; $display("FAIL store_wr_cycles: got %0d want %0d", wrs, n); end
      n_cmp++;
      if (ram_word(a) !== ref_read(a, 4)) begin
        n_err++;
        $display("FAIL store_ram: addr %h got %h want %h", a, ram_word(a), ref_read(a, 4));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, due;
    logic [31:0] w;
    logic due_lsb, exp_ff, exp_lf;
    run_fetch(32'h100, lat, w);
    pc_in = 32'h100;
    lsb_is_store = 1'b0;
    lsb_size = 2'b01;
    lsb_addr = 32'h204;
    lsb_start = 1'b1;
    fetch_start = 1'b1;
    due = 4;
    due_lsb = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      exp_ff = c == due && !due_lsb;
      exp_lf = c == due && due_lsb;
      n_cmp++;
      if ({finish_fetch, lsb_finish} !== {exp_ff, exp_lf}) begin
        n_err++;
        $display("FAIL arb_pulses@%0d: ff/lf got %b%b want %b%b", c, finish_fetch, lsb_finish, exp_ff, exp_lf);
      end
      if (exp_lf) begin
        n_cmp++;
        if (lsb_rdata !== ref_read(32'h204, 2)) begin
          n_err++;
          $display("FAIL arb_load_data: got %h want %h", lsb_rdata, ref_read(32'h204, 2));
        end
      end
      if (exp_ff) begin
        n_cmp++;
        if (instruction_out !== ref_read(32'h100, 4)) begin
          n_err++;
          $display("FAIL arb_fetch_data: got %h want %h", instruction_out, ref_read(32'h100, 4));
        end
      end
      if (c == due) begin
        due_lsb = !due_lsb;
        due += due_lsb ? 4 : 6;
      end
    end
    lsb_start = 1'b0;
    fetch_start = 1'b0;
    tick();
  endtask

  task automatic test_rollback();
    int k, lat, wrs;
    logic seen, idle_ok;
    logic [31:0] a, d, rd;
    for (int t = 0; t < 3; t++) begin
      k = t == 0 ? 2 : t == 1 ? 5 : int'($urandom_range(1, 4));
      pc_in = rand_addr();
      fetch_start = 1'b1;
      repeat (k) tick();
      n_cmp++;
      if (is_idle !== 1'b0) begin n_err++; $display("FAIL rb_busy_before: idle got %b want 0", is_idle); end
      roll_back = 1'b1;
      fetch_start = 1'b0;
      tick();
      roll_back = 1'b0;
      n_cmp++;
      if ({is_idle, finish_fetch} !== 2'b10) begin
        n_err++;
        $display("FAIL rb_fetch_abort@%0d: idle/finish got %b%b want 10", k, is_idle, finish_fetch);
      end
      seen = 1'b0;
      repeat (8) begin tick(); seen = seen | finish_fetch; end
      n_cmp++;
      if (seen !== 1'b0) begin n_err++; $display("FAIL rb_no_finish@%0d: got pulse want none", k); end
    end
    roll_back = 1'b1;
    fetch_start = 1'b1;
    lsb_is_store = 1'b0;
    lsb_addr = rand_addr();
    lsb_start = 1'b1;
    idle_ok = 1'b1;
    repeat (3) begin tick(); if (is_idle !== 1'b1) idle_ok = 1'b0; end
    fetch_start = 1'b0;
    lsb_start = 1'b0;
    n_cmp++;
    if (!idle_ok) begin n_err++; $display("FAIL rb_idle_ignores: got busy want idle"); end
    a = rand_addr();
    d = $urandom;
    run_lsb(1'b1, 2'b10, a, d, lat, wrs, rd);
    roll_back = 1'b0;
    ref_write(a, 4, d);
    n_cmp++;
    if (lat !== 5 || wrs !== 4) begin n_err++; $display("FAIL rb_store: lat %0d wrs %0d want 5 4", lat, wrs); end
    n_cmp++;
    if (ram_word(a) !== ref_read(a, 4)) begin
      n_err++;
      $display("FAIL rb_store_ram: got %h want %h", ram_word(a), ref_read(a, 4));
    end
  endtask

  task automatic test_io_gating();
    logic [31:0] d;
    int wrs, nf, lat;
    d = $urandom;
    io_buffer_full = 1'b1;
    lsb_is_store = 1'b1;
    lsb_size = 2'b00;
    lsb_addr = 32'h30000;
    lsb_wdata = d;
    lsb_start = 1'b1;
    pc_in = rand_addr();
    fetch_start = 1'b1;
    wrs = 0;
    nf = 0;
    repeat (10) begin
      tick();
      if (mem_wr) wrs++;
      if (finish_fetch) nf++;
    end
    n_cmp++;
    if (wrs !== 0) begin n_err++; $display("FAIL io_blocked: got %0d write cycles want 0", wrs); end
    n_cmp++;
    if (nf !== 1) begin n_err++; $display("FAIL io_if_progress: got %0d fetches want 1", nf); end
    io_buffer_full = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (finish_fetch) lat = c;
    end
    fetch_start = 1'b0;
    lat = -1;
    wrs = 0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (mem_wr) wrs++;
      if (lsb_finish) lat = c;
    end
    lsb_start = 1'b0;
    ref_write(32'h30000, 1, d);
    n_cmp++;
    if (lat !== 2 || wrs !== 1) begin n_err++; $display("FAIL io_store_after: lat %0d wrs %0d want 2 1", lat, wrs); end
    n_cmp++;
    if (ram[18'h30000] !== exp_mem[18'h30000]) begin
      n_err++;
      $display("FAIL io_store_ram: got %h want %h", ram[18'h30000], exp_mem[18'h30000]);
    end
  endtask

  task automatic test_rdy();
    logic [31:0] a, d, held, rd;
    logic frozen;
    int lat;
    a = rand_addr();
    lsb_is_store = 1'b0;
    lsb_size = 2'b10;
    lsb_addr = a;
    lsb_start = 1'b1;
    repeat (3) tick();
    rdy_in = 1'b0;
    held = mem_a;
    frozen = 1'b1;
    repeat (4) begin
      tick();
      if (mem_a !== held || mem_wr !== 1'b0 || lsb_finish !== 1'b0 || is_idle !== 1'b0) frozen = 1'b0;
    end
    n_cmp++;
    if (!frozen) begin n_err++; $display("FAIL rdy_load_freeze: state moved while paused"); end
    rdy_in = 1'b1;
    lat = -1;
    rd = 'x;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (lsb_finish) begin lat = c; rd = lsb_rdata; end
    end
    lsb_start = 1'b0;
    n_cmp++;
    if (lat !== 3) begin n_err++; $display("FAIL rdy_load_resume: got %0d want 3", lat); end
    n_cmp++;
    if (rd !== ref_read(a, 4)) begin n_err++; $display("FAIL rdy_load_data: got %h want %h", rd, ref_read(a, 4)); end
    a = rand_addr();
    d = $urandom;
    lsb_is_store = 1'b1;
    lsb_addr = a;
    lsb_wdata = d;
    lsb_start = 1'b1;
    repeat (2) tick();
    rdy_in = 1'b0;
    #1;
    n_cmp++;
    if (mem_wr !== 1'b0) begin n_err++; $display("FAIL rdy_wr_gate: got %b want 0", mem_wr); end
    held = mem_a;
    frozen = 1'b1;
    repeat (3) begin
      tick();
      if (mem_a !== held || mem_wr !== 1'b0) frozen = 1'b0;
    end
    n_cmp++;
    if (!frozen) begin n_err++; $display("FAIL rdy_store_freeze: state moved while paused"); end
    rdy_in = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (lsb_finish) lat = c;
    end
    lsb_start = 1'b0;
    ref_write(a, 4, d);
    n_cmp++;
    if (lat !== 3) begin n_err++; $display("FAIL rdy_store_resume: got %0d want 3", lat); end
    n_cmp++;
    if (ram_word(a) !== ref_read(a, 4)) begin
      n_err++;
      $display("FAIL rdy_store_ram: got %h want %h", ram_word(a), ref_read(a, 4));
    end
  endtask

  task automatic test_async_reset();
    lsb_is_store = 1'b1;
    lsb_size = 2'b10;
    lsb_addr = 32'h1_0004;
    lsb_wdata = $urandom;
    lsb_start = 1'b1;
    repeat (2) tick();
    #2 rst_in = 1'b0;
    #1;
    n_cmp++;
    if ({mem_a, mem_dout, mem_wr, finish_fetch, lsb_finish, instruction_out, lsb_rdata} !== '0) begin
      n_err++;
      $display("FAIL async_reset_outputs: mem_a=%h dout=%h wr=%b ins=%h rd=%h, want all 0",
               mem_a, mem_dout, mem_wr, instruction_out, lsb_rdata);
    end
    n_cmp++;
    if (is_idle !== 1'b1) begin n_err++; $display("FAIL async_reset_idle: got %b want 1", is_idle); end
    lsb_start = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    n_cmp++;
    if (is_idle !== 1'b1) begin n_err++; $display("FAIL reset_release_idle: got %b want 1", is_idle); end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      ram[18'(i)] = 8'($urandom);
      exp_mem[18'(i)] = ram[18'(i)];
    end
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_back_to_back();
    test_rollback();
    test_io_gating();
    test_rdy();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Single owner of the byte-wide RAM port. Arbitrates between two requesters:
  - IF instruction fetch, always 4 bytes.
  - LSB load/store, 1, 2 or 4 bytes.
- Serialises each access into per-byte RAM cycles and assembles results little-endian.
- Aborts speculative reads on ROB roll-back and back-pressures stores to the IO port while the IO buffer is full.

Parameters:
- ADDR_W, 32, address width.
- IO_MASK_BIT, 17, an address is IO when bits [17:16] == 2'b11.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global pause, freeze when low
- roll_back  in  1  ROB misprediction flush
- io_buffer_full  in  1  UART buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write enable (1 = write)
- fetch_start  in  1  IF request, level
- pc_in  in  32  IF fetch address
- finish_fetch  out  1  one-cycle pulse, instruction valid
- instruction_out  out  32  fetched word
- is_idle  out  1  controller in IDLE
- lsb_start  in  1  LSB request, level
- lsb_is_store  in  1  1 = store, 0 = load
- lsb_size  in  2  00 = byte, 01 = half, 10 = word
- lsb_addr  in  32  LSB byte address
- lsb_wdata  in  32  store data, low bytes used
- lsb_finish  out  1  one-cycle pulse, access done
- lsb_rdata  out  32  load data, zero-extended raw bytes

Behaviour:
- Reset (rst_in low, asynchronous):
  - state = IDLE, cnt = 0.
  - mem_a, mem_dout, mem_wr, finish_fetch, lsb_finish, instruction_out, lsb_rdata all 0.
  - last_grant = IF, is_idle = 1.
- rdy_in low:
  - All registers hold.
  - mem_wr output gated to 0; mem_wr = wr_reg & rdy_in.
- States: IDLE, FETCH, LOAD, STORE. Length n = 4 for FETCH, otherwise 1/2/4 from lsb_size.
- RAM timing: the byte at the address held on mem_a in cycle t appears on mem_din in cycle t+1.
- IDLE, at each edge:
  - Evaluate requests. With both pending, grant the requester not in last_grant (alternating). With only one pending, grant it.
  - On grant, latch base address, n and write data. mem_a <= base, cnt <= 0, update last_grant.
  - A store starts with mem_wr <= 1 and mem_dout <= byte0.
- FETCH/LOAD, at edge E_k after grant edge E0:
  - For k < n: mem_a <= base + k.
  - For k >= 2: capture mem_din into byte k-2 of the result register.
  - At E_{n+1}: capture the last byte, pulse finish_fetch or lsb_finish for one cycle with data valid that same cycle, state <= IDLE.
  - A 4-byte fetch granted at E0 shows finish at the cycle after E5.
- STORE, at edge E_k for 1 <= k < n:
  - mem_a <= base + k, mem_dout <= byte k, mem_wr stays 1.
  - At E_n: mem_wr <= 0, lsb_finish pulse, state <= IDLE.
- Back-to-back: the earliest next grant is the edge after returning to IDLE. is_idle = (state == IDLE).
- Address arithmetic is modulo 2^32; no alignment requirement.
- IO gating: an LSB store to an IO address is not granted while io_buffer_full = 1. The IF request may be granted instead. A store already in progress is unaffected.
- Roll-back, when roll_back = 1 at an edge:
  - FETCH or LOAD aborts: state <= IDLE, cnt <= 0, no finish pulse; a finish pulse scheduled for the same edge is suppressed.
  - STORE always completes, because stores are committed.
  - In IDLE during roll-back, fetch and load requests are ignored that edge; store requests remain grantable.
- Requesters hold request, address and data stable until their finish pulse. The controller latches them at grant regardless.
- Finish pulses are never asserted for both requesters in the same cycle.

Decomposition:
- Shared package (operaType-style include): state encoding; lsb_size codes; IO address compare constant.
- No sub-module is needed. One always block for the FSM and counter, one for result assembly.

Test Plan:
- IF alone, pc_in = 0x100 with RAM[0x100..0x103] = 13,05,00,00: finish_fetch pulses 5 cycles after grant; instruction_out = 0x00000513; mem_a sequence 0x100..0x103.
- LSB word store, addr 0x200, wdata 0xDEADBEEF: mem_wr high 4 cycles writing EF,BE,AD,DE to 0x200..0x203, then lsb_finish; RAM reads back 0xDEADBEEF.
- Simultaneous fetch_start and lsb_start (load half, 0x204), last_grant = IF: LSB served first, lsb_rdata = 0x0000xxxx; fetch follows immediately with no extra idle cycle beyond the return to IDLE; repeat to confirm alternation.
- Roll-back at cycle 2 of a fetch: no finish_fetch; is_idle = 1 next cycle. Same test on a store: store completes with all bytes written.
- Byte store to 0x30000 with io_buffer_full = 1 for 10 cycles while IF requests: IF fetches proceed, mem_wr stays 0 for 0x30000; once full drops the store is granted and lsb_finish pulses.
- rdy_in low mid-load and rst_in low mid-store: with rdy_in low, mem_wr = 0 and state/cnt frozen, and the load resumes correctly. With rst_in low, all outputs return to 0 asynchronously and state = IDLE.
